// File: rtl/mult_sequencer_if.sv
// Handshake and data bus of the sequential signed multiplier.
// The master side drives the requests and the multiplicand; the slave side returns the
// product registers and the done flag.
interface mult_sequencer_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Switches;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Done;

    modport master (
        output Run, ClearA_LoadB, Switches,
        input  Aval, Bval, X, Done
    );

    modport slave (
        input  Run, ClearA_LoadB, Switches,
        output Aval, Bval, X, Done
    );
endinterface

// File: rtl/mult_sequencer.sv
// Sequential 8x8 signed (Booth-free, add/shift) multiplier.
// {X,A,B} forms a 17-bit shift register. The product ends up with the high byte in A and the
// low byte in B. The last iteration subtracts the multiplicand to account for the sign weight
// of the multiplier MSB.
module mult_sequencer (
    input  logic              Clk,
    input  logic              Reset,
    mult_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

    state_t     state;
    state_t     next_state;

    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       x_reg;
    logic [2:0] cnt;

    // Run is sampled into run_q. The armed flag is set only after run_q has been seen low, so a
    // Run held through reset or through DONE cannot start another multiply.
    logic       run_q;
    logic       armed;
    logic       start;

    logic       do_load;
    logic       do_clear;
    logic       do_add;
    logic       do_shift;

    logic [8:0] operand;
    logic [8:0] addend;
    logic [8:0] sum;

    // Load has priority over a start request in IDLE.
    assign start = (state == IDLE) && !bus.ClearA_LoadB && run_q && armed;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? CLR : IDLE;
            CLR:     next_state = ADD;
            ADD:     next_state = SHIFT;
            SHIFT:   next_state = (cnt == 3'd7) ? DONE : ADD;
            DONE:    next_state = bus.Run ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the state
    always_comb begin
        do_load  = 1'b0;
        do_clear = 1'b0;
        do_add   = 1'b0;
        do_shift = 1'b0;
        case (state)
            IDLE:    do_load  = bus.ClearA_LoadB;
            CLR:     do_clear = 1'b1;
            ADD:     do_add   = 1'b1;
            SHIFT:   do_shift = 1'b1;
            default: ;
        endcase
    end

    // 9-bit adder: sign-extended multiplicand, negated on the final iteration
    always_comb begin
        operand = {bus.Switches[7], bus.Switches};
        addend  = (cnt == 3'd7) ? (~operand + 9'd1) : operand;
        sum     = {x_reg, a_reg} + addend;
    end

    // Run sampling and re-arm tracking
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            run_q <= bus.Run;
            if (!run_q) begin
                armed <= 1'b1;
            end else if (start) begin
                armed <= 1'b0;
            end
        end
    end

    // A/B/X shift register and iteration counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg <= 8'd0;
            b_reg <= 8'd0;
            x_reg <= 1'b0;
            cnt   <= 3'd0;
        end else if (do_load) begin
            a_reg <= 8'd0;
            x_reg <= 1'b0;
            b_reg <= bus.Switches;
        end else if (do_clear) begin
            a_reg <= 8'd0;
            x_reg <= 1'b0;
            cnt   <= 3'd0;
        end else if (do_add) begin
            if (b_reg[0]) begin
                a_reg <= sum[7:0];
                x_reg <= sum[8];
            end
        end else if (do_shift) begin
            a_reg <= {x_reg, a_reg[7:1]};
            b_reg <= {a_reg[0], b_reg[7:1]};
            cnt   <= cnt + 3'd1;
        end
    end

    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.X    = x_reg;
    assign bus.Done = (state == DONE);

endmodule
